// File: rtl/dvi_pattern_gen.sv
// DVI test-pattern colour generator: per-frame mode/frame-counter register,
// four selectable patterns, DE/mask override, fixed 2-cycle registered latency.
module dvi_pattern_gen #(
    parameter int CW        = 6,
    parameter int XW        = 11,
    parameter int YW        = 10,
    parameter int FW        = 11,
    parameter int BAND1_Y   = 200,
    parameter int BAND2_Y   = 400,
    parameter int SPLIT_X   = 512,
    parameter int BAR_SHIFT = 7,
    parameter int CHK_SHIFT = 4
) (
    input  logic            CLK,
    input  logic            RESET_N,
    input  logic [XW-1:0]   X,
    input  logic [YW-1:0]   Y,
    input  logic            DE,
    input  logic            FRAME_START,
    input  logic [1:0]      MODE_REQ,
    input  logic            FREEZE,
    input  logic [3*CW-1:0] SOLID_RGB,
    input  logic            MASK,
    input  logic            LIGHT,
    output logic [CW-1:0]   R,
    output logic [CW-1:0]   G,
    output logic [CW-1:0]   B,
    output logic            DE_OUT,
    output logic [FW-1:0]   FRAME,
    output logic [1:0]      MODE
);
    // Only the low bits of X+FRAME are ever observed, so the sum is kept just
    // wide enough for the colour value and the checker select bit.
    localparam int SW = (CW > CHK_SHIFT + 1) ? CW : CHK_SHIFT + 1;
    localparam logic [YW-1:0] BAND1 = YW'(BAND1_Y);
    localparam logic [YW-1:0] BAND2 = YW'(BAND2_Y);
    localparam logic [XW-1:0] SPLIT = XW'(SPLIT_X);
    localparam logic [CW-1:0] ONES  = '1;
    localparam logic [CW-1:0] ZERO  = '0;

    logic [FW-1:0]   frame_q, frame_d;
    logic [1:0]      mode_q, mode_d;
    logic [1:0]      de_pipe_q;
    logic            mask_q, light_q;
    logic [3*CW-1:0] col_q, col_d;
    logic [3*CW-1:0] rgb_q, rgb_d;

    logic [SW-1:0]   xf;
    logic [CW-1:0]   yf;
    logic [2:0]      bar_idx;
    logic            chk;

    always_comb begin
        frame_d = frame_q;
        mode_d  = mode_q;
        if (FRAME_START) begin
            mode_d = MODE_REQ;
            if (!FREEZE) frame_d = frame_q + FW'(1);
        end
    end

    assign xf      = SW'(X) + SW'(frame_q);
    assign yf      = CW'(Y) + CW'(frame_q);
    assign bar_idx = X[BAR_SHIFT+2:BAR_SHIFT];
    assign chk     = xf[CHK_SHIFT] ^ Y[CHK_SHIFT];

    always_comb begin
        col_d = '0;
        case (mode_q)
            2'd0: begin
                if (Y < BAND1)
                    col_d = (X[0] ^ Y[0]) ? {ONES, ONES, ONES} : '0;
                else if (Y < BAND2)
                    col_d = (X < SPLIT) ? {ZERO, xf[CW-1:0], ZERO} : {yf, ZERO, ZERO};
                else
                    col_d = {CW'(X), CW'(X), yf};
            end
            2'd1: col_d = {{CW{~bar_idx[1]}}, {CW{~bar_idx[2]}}, {CW{~bar_idx[0]}}};
            2'd2: col_d = SOLID_RGB;
            default: col_d = chk ? {ONES, ONES, ONES} : '0;
        endcase
    end

    always_comb begin
        rgb_d = col_q;
        if (!de_pipe_q[0])
            rgb_d = '0;
        else if (mask_q)
            rgb_d = {3*CW{light_q}};
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            frame_q   <= '0;
            mode_q    <= '0;
            de_pipe_q <= '0;
            mask_q    <= 1'b0;
            light_q   <= 1'b0;
            col_q     <= '0;
            rgb_q     <= '0;
        end else begin
            frame_q   <= frame_d;
            mode_q    <= mode_d;
            de_pipe_q <= {de_pipe_q[0], DE};
            mask_q    <= MASK;
            light_q   <= LIGHT;
            col_q     <= col_d;
            rgb_q     <= rgb_d;
        end
    end

    assign R      = rgb_q[3*CW-1:2*CW];
    assign G      = rgb_q[2*CW-1:CW];
    assign B      = rgb_q[CW-1:0];
    assign DE_OUT = de_pipe_q[1];
    assign FRAME  = frame_q;
    assign MODE   = mode_q;
endmodule

// File: tb/tb_dvi_pattern_gen.sv
// Directed bench for dvi_pattern_gen with hand-computed expected colours.
module tb_dvi_pattern_gen;
    localparam int CW = 6, XW = 11, YW = 10, FW = 11;

    logic            CLK = 1'b0;
    logic            RESET_N;
    logic [XW-1:0]   X;
    logic [YW-1:0]   Y;
    logic            DE, FRAME_START, FREEZE, MASK, LIGHT;
    logic [1:0]      MODE_REQ;
    logic [3*CW-1:0] SOLID_RGB;
    logic [CW-1:0]   R, G, B;
    logic            DE_OUT;
    logic [FW-1:0]   FRAME;
    logic [1:0]      MODE;

    int n_vec = 0;
    int n_err = 0;

    dvi_pattern_gen dut (
        .CLK(CLK), .RESET_N(RESET_N), .X(X), .Y(Y), .DE(DE),
        .FRAME_START(FRAME_START), .MODE_REQ(MODE_REQ), .FREEZE(FREEZE),
        .SOLID_RGB(SOLID_RGB), .MASK(MASK), .LIGHT(LIGHT),
        .R(R), .G(G), .B(B), .DE_OUT(DE_OUT), .FRAME(FRAME), .MODE(MODE)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic chk_rgb(input string tag, input int r, input int g, input int b, input int de);
        chk({tag, ".R"}, int'(R), r);
        chk({tag, ".G"}, int'(G), g);
        chk({tag, ".B"}, int'(B), b);
        chk({tag, ".DE_OUT"}, int'(DE_OUT), de);
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic fs_pulse();
        FRAME_START = 1'b1;
        step();
        FRAME_START = 1'b0;
        step();
    endtask

    task automatic pix(input int x, input int y);
        X = XW'(x);
        Y = YW'(y);
        DE = 1'b1;
    endtask

    initial begin
        RESET_N = 1'b0; X = '0; Y = '0; DE = 1'b0; FRAME_START = 1'b0;
        MODE_REQ = 2'd0; FREEZE = 1'b0; SOLID_RGB = '0; MASK = 1'b0; LIGHT = 1'b0;
        step(2);
        chk_rgb("rst", 0, 0, 0, 0);
        chk("rst.FRAME", int'(FRAME), 0);
        chk("rst.MODE", int'(MODE), 0);
        RESET_N = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk_rgb("idle", 0, 0, 0, 0);
            chk("idle.FRAME", int'(FRAME), 0);
            chk("idle.MODE", int'(MODE), 0);
        end

        // Mode 0 bands with FRAME=3
        repeat (3) fs_pulse();
        chk("f3.FRAME", int'(FRAME), 3);
        pix(10, 250);  step(2); chk_rgb("m0.mid_l", 0, 13, 0, 1);
        pix(600, 250); step(2); chk_rgb("m0.mid_r", 61, 0, 0, 1);
        pix(3, 4);     step(2); chk_rgb("m0.top", 63, 63, 63, 1);
        pix(2, 4);     step(2); chk_rgb("m0.top0", 0, 0, 0, 1);
        pix(100, 450); step(2); chk_rgb("m0.bot", 36, 36, 5, 1);

        // Mode request only takes effect at FRAME_START; same-cycle pixel uses old state
        MODE_REQ = 2'd1;
        step(3);
        chk("mreq.hold", int'(MODE), 0);
        pix(10, 250);
        FRAME_START = 1'b1;
        step();
        FRAME_START = 1'b0;
        pix(300, 250);
        step();
        chk_rgb("same_cyc", 0, 13, 0, 1);
        chk("fs.MODE", int'(MODE), 1);
        chk("fs.FRAME", int'(FRAME), 4);
        pix(640, 250);
        step();
        chk_rgb("m1.cyan", 0, 63, 63, 1);
        step();
        chk_rgb("m1.red", 63, 0, 0, 1);
        pix(50, 250);  step(2); chk_rgb("m1.white", 63, 63, 63, 1);

        // Frame counter wrap, then freeze
        DE = 1'b0;
        repeat (2043) fs_pulse();
        chk("wrap.pre", int'(FRAME), 2047);
        fs_pulse();
        chk("wrap.post", int'(FRAME), 0);
        FREEZE = 1'b1; MODE_REQ = 2'd2;
        fs_pulse();
        chk("frz.FRAME", int'(FRAME), 0);
        chk("frz.MODE", int'(MODE), 2);

        // Solid colour with mask override and DE blanking
        SOLID_RGB = {6'd5, 6'd10, 6'd15};
        MASK = 1'b1; LIGHT = 1'b1;
        pix(7, 7);
        step(2); chk_rgb("m2.mask_w", 63, 63, 63, 1);
        MASK = 1'b0;
        step();  chk_rgb("m2.lag1", 63, 63, 63, 1);
        step();  chk_rgb("m2.solid", 5, 10, 15, 1);
        DE = 1'b0;
        step();  chk_rgb("m2.lag2", 5, 10, 15, 1);
        step();  chk_rgb("m2.blank", 0, 0, 0, 0);
        MASK = 1'b1; LIGHT = 1'b0; DE = 1'b1;
        step(2); chk_rgb("m2.mask_k", 0, 0, 0, 1);
        MASK = 1'b0;

        // Scrolling checker, FRAME=1
        FREEZE = 1'b0; MODE_REQ = 2'd3;
        fs_pulse();
        chk("m3.FRAME", int'(FRAME), 1);
        chk("m3.MODE", int'(MODE), 3);
        pix(14, 0);  step(2); chk_rgb("m3.c00", 0, 0, 0, 1);
        pix(14, 16); step(2); chk_rgb("m3.c01", 63, 63, 63, 1);
        pix(15, 0);  step(2); chk_rgb("m3.scroll", 63, 63, 63, 1);

        // Asynchronous reset pulse mid-line
        #1 RESET_N = 1'b0;
        #1;
        chk_rgb("arst", 0, 0, 0, 0);
        chk("arst.FRAME", int'(FRAME), 0);
        chk("arst.MODE", int'(MODE), 0);
        #2 RESET_N = 1'b1;
        step();
        chk("post.lat1", int'(DE_OUT), 0);
        step();
        chk_rgb("post.px", 63, 63, 63, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got 0 expected 1");
        $fatal(1);
    end
endmodule
